// File: rtl/apb_timer_sched.sv
// apb_timer_sched: round-robin sharing of one APB timer between NUM_REQ delay requesters
module apb_timer_sched #(
    parameter int          NUM_REQ   = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [32*NUM_REQ-1:0] REQ_TIME,
    output logic [NUM_REQ-1:0]   GNT,
    output logic [NUM_REQ-1:0]   ACK,
    output logic                 ERR,
    output logic                 BUSY,
    output logic                 M_APB_PSEL,
    output logic                 M_APB_PENABLE,
    output logic                 M_APB_PWRITE,
    output logic [15:0]          M_APB_PADDR,
    output logic [31:0]          M_APB_PWDATA,
    input  logic                 M_APB_PREADY,
    input  logic                 M_APB_PSLVERR,
    input  logic                 TIMER_DONE
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    typedef enum logic [3:0] {
        IDLE, CNT_SETUP, CNT_ACCESS, ENA_SETUP, ENA_ACCESS,
        WAIT_DONE, DIS_SETUP, DIS_ACCESS, RESP
    } state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       rr_ptr, winner, pick;
    logic [IW:0]         cand;
    logic                found, err_flag, is_cnt, is_ena, is_dis;
    logic [31:0]         time_q;
    logic [NUM_REQ-1:0]  win_oh;

    assign win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;

    // first pending request at or after the round-robin pointer, wrapping
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(i);
            cand = (cand >= (IW+1)'(NUM_REQ)) ? cand - (IW+1)'(NUM_REQ) : cand;
            if (REQ[cand[IW-1:0]]) begin
                pick  = cand[IW-1:0];
                found = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state; errors on CNT/ENA jump straight to disabling the timer
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       state_nxt = found ? CNT_SETUP : IDLE;
            CNT_SETUP:  state_nxt = CNT_ACCESS;
            CNT_ACCESS: state_nxt = !M_APB_PREADY ? CNT_ACCESS : M_APB_PSLVERR ? DIS_SETUP : ENA_SETUP;
            ENA_SETUP:  state_nxt = ENA_ACCESS;
            ENA_ACCESS: state_nxt = !M_APB_PREADY ? ENA_ACCESS : M_APB_PSLVERR ? DIS_SETUP : WAIT_DONE;
            WAIT_DONE:  state_nxt = TIMER_DONE ? DIS_SETUP : WAIT_DONE;
            DIS_SETUP:  state_nxt = DIS_ACCESS;
            DIS_ACCESS: state_nxt = M_APB_PREADY ? RESP : DIS_ACCESS;
            RESP:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // winner, latched tick count, sticky slave error and round-robin pointer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            winner   <= '0;
            rr_ptr   <= '0;
            time_q   <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                winner <= pick;
                time_q <= REQ_TIME[32*pick +: 32];
            end
            if (M_APB_PENABLE && M_APB_PREADY && M_APB_PSLVERR) err_flag <= 1'b1;
            if (state == RESP) begin
                err_flag <= 1'b0;
                rr_ptr   <= (winner == LAST) ? '0 : winner + 1'b1;
            end
        end
    end

    // outputs decoded purely from registered state so REQ/TIMER_DONE never reach them
    always_comb begin
        is_cnt        = (state == CNT_SETUP) || (state == CNT_ACCESS);
        is_ena        = (state == ENA_SETUP) || (state == ENA_ACCESS);
        is_dis        = (state == DIS_SETUP) || (state == DIS_ACCESS);
        M_APB_PSEL    = is_cnt || is_ena || is_dis;
        M_APB_PENABLE = (state == CNT_ACCESS) || (state == ENA_ACCESS) || (state == DIS_ACCESS);
        M_APB_PWRITE  = M_APB_PSEL;
        M_APB_PADDR   = is_cnt ? BASE_ADDR + 16'd4 : (is_ena || is_dis) ? BASE_ADDR : 16'h0;
        M_APB_PWDATA  = is_cnt ? time_q : is_ena ? 32'h1 : 32'h0;
        BUSY          = state != IDLE;
        GNT           = BUSY ? win_oh : '0;
        ACK           = (state == RESP) ? win_oh : '0;
        ERR           = (state == RESP) && err_flag;
    end
endmodule

// File: doc/apb_timer_sched.md
# apb_timer_sched

Round-robin scheduler that shares one APB timer peripheral (CTRL at offset 0x0, COUNTER at offset 0x4, DONE output) between NUM_REQ hardware requesters. It acts as the sole APB master on the timer's slave port and arbitrates pending delay requests. For each granted request it programs COUNTER with the requested tick count, enables the timer, and waits for the timer's DONE. It then disables the timer and pulses an acknowledge to the winning requester.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- BASE_ADDR, 16'h0000, APB base address of the timer (CTRL = BASE_ADDR, COUNTER = BASE_ADDR+4)
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset (one clock, asynchronous active-high reset)
- REQ  in  NUM_REQ  per-requester delay request level
- REQ_TIME  in  32*NUM_REQ  tick count per requester; slice i = [32*i+31:32*i]
- GNT  out  NUM_REQ  one-hot; the requester currently being serviced
- ACK  out  NUM_REQ  one-cycle pulse; the delay for that requester has expired
- ERR  out  1  one-cycle pulse with ACK when any APB transfer of the service returned PSLVERR
- BUSY  out  1  a service is in progress (state != IDLE)
- M_APB_PSEL, M_APB_PENABLE, M_APB_PWRITE  out  1  APB master controls
- M_APB_PADDR  out  16  APB address
- M_APB_PWDATA  out  32  APB write data
- M_APB_PREADY, M_APB_PSLVERR  in  1  APB slave response
- TIMER_DONE  in  1  DONE output of the timer

## Operation
- FSM states: IDLE, CNT_SETUP, CNT_ACCESS, ENA_SETUP, ENA_ACCESS, WAIT_DONE, DIS_SETUP, DIS_ACCESS, RESP.
- IDLE:
  - If any REQ bit is set, select a winner round-robin, starting from the index after the last winner. After reset the search starts at index 0.
  - Latch the winner's REQ_TIME into a 32-bit register, set GNT to the winner, and go to CNT_SETUP.
- APB transfers:
  - SETUP state: PSEL=1, PENABLE=0, PWRITE=1. Move to the matching ACCESS state next cycle.
  - ACCESS state: PSEL=1, PENABLE=1, PWRITE=1. Hold PADDR and PWDATA stable until PREADY=1.
  - In any state other than SETUP and ACCESS, PSEL=0 and PENABLE=0.
- CNT: PADDR=BASE_ADDR+4, PWDATA = latched time. On PREADY, go to ENA_SETUP.
- ENA: PADDR=BASE_ADDR, PWDATA=32'h1. On PREADY, go to WAIT_DONE.
- WAIT_DONE: when TIMER_DONE=1, go to DIS_SETUP.
- DIS: PADDR=BASE_ADDR, PWDATA=32'h0. On PREADY, go to RESP.
- RESP:
  - ACK[winner]=1 for this one cycle. ERR=1 if a sticky error flag is set.
  - Clear GNT, clear the error flag, advance the round-robin pointer to winner+1 (mod NUM_REQ), and return to IDLE.
- PSLVERR:
  - Sampled on every accepted transfer (ACCESS state with PREADY=1). When set, it sets the sticky error flag.
  - An error on CNT or ENA skips WAIT_DONE and goes directly to DIS_SETUP. The timer is always left disabled.
- REQ is sampled only in IDLE. Deasserting REQ mid-service does not abort the service; the ACK is still issued.
- A requester must drop REQ in the cycle after its ACK; otherwise it is re-arbitrated as a new request.
- REQ_TIME=0 is legal. TIMER_DONE is 1 as soon as the enable lands, and the full sequence still runs.
- PWDATA and PADDR are 0 in states that do not drive an APB transfer.

## Timing
- Reset values: GNT=0, ACK=0, ERR=0, BUSY=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. State is IDLE and the round-robin pointer is 0.
- All outputs are registered or decoded from the state register. No combinational path from REQ or TIMER_DONE to any output.
- Arbitration: REQ seen in IDLE at edge t gives GNT and CNT_SETUP at t+1.
- Each APB write with a zero-wait slave takes 2 cycles. Each PREADY=0 cycle adds one cycle.
- TIMER_DONE is ignored outside WAIT_DONE, so a stale DONE from a previous service is never used.
- With a zero-wait slave and REQ_TIME=N:
  - ACK asserts no earlier than N cycles after the COUNTER write is accepted.
  - ACK asserts no later than N+6 cycles after it.
- Back-to-back service: the next arbitration occurs in the IDLE cycle immediately after RESP. Minimum spacing between ACKs is 9 cycles.
- Asynchronous RST mid-service forces every output to its reset value immediately and aborts any APB transfer. No ACK is issued for the aborted request.

## Test plan
- Single request, REQ[0]=1, REQ_TIME=10, zero-wait timer:
  - Writes are COUNTER=10, then CTRL=1, then CTRL=0.
  - ACK[0] pulses once, 10..16 cycles after the COUNTER write is accepted. ERR=0.
- All four REQ bits set simultaneously, each with REQ_TIME=3, held until their ACK:
  - ACK order is 0,1,2,3. GNT is one-hot throughout.
  - With REQ[0] reasserted afterwards, the next winner follows the round-robin pointer.
- REQ_TIME=0:
  - The sequence completes. ACK is issued within 8 cycles of grant.
  - The COUNTER write data is 0.
- Slave inserts 3 wait states (PREADY=0) on each transfer:
  - PADDR, PWDATA and PSEL stay stable throughout. ACK is delayed by exactly 9 extra cycles.
- PSLVERR=1 on the ENA write:
  - No WAIT_DONE. The CTRL=0 write is still issued.
  - ACK pulses together with ERR=1.
- RST asserted in WAIT_DONE:
  - Outputs go to 0 without waiting for a clock edge.
  - After release, a new REQ[2] is serviced normally, with arbitration starting at index 0.
